systolic_seq_ctrl: RTL
======================

// Module: systolic_seq_ctrl
// PURPOSE
//   Sequencer for one 4x4 systolic tile (2x2 grid of base PEs, 2 lanes each; 4 row lanes, 4 col lanes).
//   On START it clears the tile accumulators and walks the inner dimension K.
//   It emits per-lane skewed valid masks and operand-buffer read addresses, and gates the tile EN.
//   It then drains the array pipeline and pulses CAPTURE/DONE when results are stable.
//   It sits between the operand buffers and the tile's N_RX*/N_CX* inputs.
// PARAMETERS
//   N          4   number of row lanes; number of col lanes is equal to N
//   KW         8   width of K_LEN and of each per-lane address
//   DRAIN_CYC  6   enabled cycles after the last feed until outputs settle (2*N-2 for 4x4)
// PORTS
//   CLK       in   1       clock, rising edge
//   RSTN      in   1       asynchronous active-low reset
//   START     in   1       begin an operation; sampled only in IDLE
//   K_LEN     in   KW      inner-dimension length; sampled with START
//   STALL     in   1       operand buffer not ready; freezes sequencing
//   ABORT     in   1       cancel the current operation
//   BUSY      out  1       high in every state except IDLE
//   ACC_CLR   out  1       one-cycle accumulator clear (LOAD state)
//   TILE_EN   out  1       drives the tile EN input
//   ROW_VLD   out  N       row lane i presents a real operand; 0 = feeder injects zero
//   COL_VLD   out  N       col lane j presents a real operand; 0 = feeder injects zero
//   ROW_ADDR  out  N*KW    lane i occupies bits [i*KW +: KW]; k index into the A buffer
//   COL_ADDR  out  N*KW    lane j occupies bits [j*KW +: KW]; k index into the B buffer
//   CAPTURE   out  1       one-cycle pulse: the result sink latches the tile outputs
//   DONE      out  1       one-cycle pulse, coincident with CAPTURE
// BEHAVIOUR
//   States:
//   - IDLE -> LOAD on START when K_LEN != 0.
//   - IDLE -> FIN on START when K_LEN == 0 (no-op). In this case CAPTURE=0 and DONE=1.
//   - LOAD -> FEED after 1 cycle.
//   - FEED -> DRAIN when cnt == K+N-2 and the cycle is enabled.
//   - DRAIN -> FIN after DRAIN_CYC enabled cycles.
//   - FIN -> IDLE.
//   - START while BUSY is ignored. K is latched into an internal register on the accepted START.
//   Counter and enable:
//   - cnt is KW+1 bits wide and is cleared on entry to FEED and on entry to DRAIN.
//   - cnt advances only when TILE_EN=1.
//   - TILE_EN = (FEED|DRAIN) & ~STALL, combinational. It is 0 in IDLE, LOAD and FIN.
//   Skew decode (combinational from registered cnt; zero outside FEED):
//   - ROW_VLD[i] = FEED & (cnt >= i) & (cnt < i+K).
//   - ROW_ADDR[i] = (cnt - i) truncated to KW bits. It is meaningful only when ROW_VLD[i]=1.
//   - COL_VLD and COL_ADDR are identical to the row decode.
//   - During STALL, VLD and ADDR hold their values (cnt frozen) and TILE_EN=0.
//   Latency:
//   - From START sampled in cycle t with no stalls, DONE and CAPTURE occur in cycle t+K+N+DRAIN_CYC+1.
//   - Each STALL cycle in FEED or DRAIN adds exactly one cycle.
//   Priority and resets:
//   - ABORT in any non-IDLE state: next state is IDLE, no DONE or CAPTURE. ABORT has priority over STALL.
//   - ABORT in IDLE has no effect. ABORT and START together in IDLE: START is ignored.
//   - RSTN low, at any time including mid-operation: state=IDLE, cnt=0, K register=0.
//     All outputs are 0 asynchronously.
//   K_LEN range and wrap:
//   - K_LEN = 2^KW-1 is legal. cnt cannot wrap because it is KW+1 bits.
//   - ADDR never exceeds K-1 while its lane is valid.
// TESTING (N=4, DRAIN_CYC=6)
//   1. START at cycle 0, K_LEN=3, no stall.
//      -> ACC_CLR at cycle 1; TILE_EN over cycles 2..13.
//      -> ROW_VLD[0] over cycles 2..4 with addr 0,1,2; ROW_VLD[3] over cycles 5..7 with addr 0,1,2.
//      -> DONE and CAPTURE at cycle 14; BUSY low at cycle 15.
//   2. As test 1, with STALL high in cycles 4 and 9.
//      -> TILE_EN=0 in those cycles and VLD/ADDR hold.
//      -> DONE at cycle 16.
//   3. START with K_LEN=0 -> DONE=1 at cycle 1, CAPTURE=0, TILE_EN never asserted.
//   4. K_LEN=5; ABORT at cycle 4.
//      -> IDLE at cycle 5 with all outputs 0 and no DONE.
//      -> A new START at cycle 6 runs cleanly to DONE at cycle 22.
//   5. RSTN low at cycle 7 of a K=3 run -> all outputs 0 immediately; after release the block is IDLE.
//      A second START during BUSY is ignored: DONE still occurs at cycle 14 of the first operation.
//   6. K_LEN=255 -> COL_ADDR[3] = 254 at cnt=257; VLD=0 at cnt=258; FEED ends after 258 enabled cycles.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Purpose: sequences one NxN systolic tile: clear, skewed K-walk feed, drain, capture/done.
// Latency: START in cycle t -> DONE/CAPTURE in cycle t+K+N+DRAIN_CYC+1 (K=0: t+1, DONE only).
// Backpressure: STALL freezes cnt, VLD and ADDR and drops TILE_EN; each stall cycle adds one cycle.
//
// Ports:
//   CLK, RSTN           clock (rising edge), async active-low reset
//   START, K_LEN        begin an operation of inner length K_LEN (accepted only in IDLE)
//   STALL, ABORT        operand buffer not ready / cancel current operation
//   BUSY, ACC_CLR       not idle / one-cycle accumulator clear
//   TILE_EN             tile enable, high in FEED/DRAIN when not stalled
//   ROW_VLD, COL_VLD    per-lane real-operand flags (0 = feeder injects zero)
//   ROW_ADDR, COL_ADDR  per-lane k index, lane i at [i*KW +: KW]
//   CAPTURE, DONE       one-cycle completion pulses (CAPTURE suppressed for K=0)
module systolic_seq_ctrl #(
    parameter int N         = 4,
    parameter int KW        = 8,
    parameter int DRAIN_CYC = 6
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            START,
    input  logic [KW-1:0]   K_LEN,
    input  logic            STALL,
    input  logic            ABORT,
    output logic            BUSY,
    output logic            ACC_CLR,
    output logic            TILE_EN,
    output logic [N-1:0]    ROW_VLD,
    output logic [N-1:0]    COL_VLD,
    output logic [N*KW-1:0] ROW_ADDR,
    output logic [N*KW-1:0] COL_ADDR,
    output logic            CAPTURE,
    output logic            DONE
);

    // One spare bit so K+N-2 (up to 2^KW+1 for N=4) never wraps.
    localparam int CW = KW + 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [KW-1:0]   k_reg, k_nxt;
    logic [CW-1:0]   feed_last;
    logic            in_feed;
    logic            tile_en;

    // Last feed cycle: the operand for k=K-1 enters lane N-1.
    assign feed_last = {1'b0, k_reg} + CW'(N - 2);
    assign in_feed   = (state == S_FEED);
    assign tile_en   = ((state == S_FEED) || (state == S_DRAIN)) && !STALL;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
            cnt   <= '0;
            k_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            k_reg <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k_reg;
        case (state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    k_nxt     = K_LEN;
                    cnt_nxt   = '0;
                    state_nxt = (K_LEN == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (tile_en) begin
                    if (cnt == feed_last) begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (tile_en) begin
                    if (cnt == DRAIN_LAST) begin
                        state_nxt = S_FIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // ABORT wins over everything, including STALL.
        if (ABORT && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    assign BUSY    = (state != S_IDLE);
    assign ACC_CLR = (state == S_LOAD);
    assign TILE_EN = tile_en;
    assign DONE    = (state == S_FIN);
    // A K=0 no-op reaches FIN with k_reg=0: report done but capture nothing.
    assign CAPTURE = (state == S_FIN) && (k_reg != '0);

    // Skew decode: lane i sees operand k=cnt-i while i <= cnt < i+K.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [CW-1:0] diff;
        assign lo   = CW'(i);
        assign hi   = {1'b0, k_reg} + CW'(i);
        assign diff = cnt - lo;
        assign ROW_VLD[i]           = in_feed && (cnt >= lo) && (cnt < hi);
        assign ROW_ADDR[i*KW +: KW] = in_feed ? diff[KW-1:0] : '0;
    end

    // Square tile: column lanes follow the same skew as the rows.
    assign COL_VLD  = ROW_VLD;
    assign COL_ADDR = ROW_ADDR;

endmodule
